// File: rtl/regfile_write_port.sv
// Write side of the 8-entry general register bank: a valid/ready request port
// feeding a one-entry commit stage that writes exactly one register per commit.
module regfile_write_port #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    output logic             pend_valid,
    output logic [2:0]       pend_addr,
    output logic [WIDTH-1:0] pend_data,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] H
);

    localparam int unsigned DEPTH = 8;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             commit;
    logic             accept;

    // A full stage can only drain while hold is low, so that is when room appears.
    assign wr_ready = ~pend_valid | ~hold;
    assign commit   = pend_valid & ~hold;
    assign accept   = wr_valid & wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VALUE;
            end
            pend_valid <= 1'b0;
            pend_addr  <= 3'b000;
            pend_data  <= '0;
        end else begin
            if (commit) begin
                regs[pend_addr] <= pend_data;
            end
            // A new accept refills the stage in the same edge the old entry commits.
            if (accept) begin
                pend_valid <= 1'b1;
                pend_addr  <= wr_addr;
                pend_data  <= wr_data;
            end else if (commit) begin
                pend_valid <= 1'b0;
                pend_addr  <= 3'b000;
                pend_data  <= '0;
            end
        end
    end

    // Index 7 maps to A down to index 0 on H, matching the read-select encoding.
    assign A = regs[7];
    assign B = regs[6];
    assign C = regs[5];
    assign D = regs[4];
    assign E = regs[3];
    assign F = regs[2];
    assign G = regs[1];
    assign H = regs[0];

endmodule

// File: tb/tb_regfile_write_port.sv
// Randomized and directed bench for regfile_write_port against a queue-based model.
module tb_regfile_write_port;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             hold;
    logic             pend_valid;
    logic [2:0]       pend_addr;
    logic [WIDTH-1:0] pend_data;
    logic [WIDTH-1:0] A, B, C, D, E, F, G, H;

    regfile_write_port #(.WIDTH(WIDTH), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       addr;
        logic [WIDTH-1:0] data;
    } req_t;

    // Reference model: register contents plus the not-yet-committed writes.
    logic [WIDTH-1:0] m_regs [8];
    req_t             m_q [$];
    logic             last_accepted;
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_reg(input int idx);
        case (idx)
            7: return A;
            6: return B;
            5: return C;
            4: return D;
            3: return E;
            2: return F;
            1: return G;
            default: return H;
        endcase
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".pend_valid"}, 32'(pend_valid), 32'(m_q.size() != 0));
        check({tag, ".pend_addr"}, 32'(pend_addr), (m_q.size() != 0) ? 32'(m_q[0].addr) : 32'd0);
        check({tag, ".pend_data"}, 32'(pend_data), (m_q.size() != 0) ? 32'(m_q[0].data) : 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.reg%0d", tag, i), 32'(dut_reg(i)), 32'(m_regs[i]));
        end
    endtask

    // Apply one cycle of inputs, check wr_ready, clock, update the model, check outputs.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [2:0] a, input logic [WIDTH-1:0] d, input logic h);
        logic ready_exp;
        rst = r; wr_valid = v; wr_addr = a; wr_data = d; hold = h;
        #1;
        ready_exp = (m_q.size() == 0) || !h;
        if (!r) check({tag, ".wr_ready"}, 32'(wr_ready), 32'(ready_exp));
        @(posedge clk);
        last_accepted = 1'b0;
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_q.delete();
        end else begin
            if (m_q.size() != 0 && !h) begin
                m_regs[m_q[0].addr] = m_q[0].data;
                void'(m_q.pop_front());
            end
            if (v && ready_exp) begin
                m_q.push_back('{addr: a, data: d});
                last_accepted = 1'b1;
            end
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        logic             rv, rh;
        logic [2:0]       ra;
        logic [WIDTH-1:0] rd;

        // Reset with a request offered: nothing may be accepted.
        step("rst0", 1'b1, 1'b1, 3'd7, 16'h5555, 1'b0);
        step("rst1", 1'b1, 1'b1, 3'd7, 16'h5555, 1'b0);
        check("rst.A", 32'(A), 32'h0);
        check("rst.wr_ready", 32'(wr_ready), 32'd1);

        // Single write: visible in the stage one cycle, then on A.
        step("single0", 1'b0, 1'b1, 3'b111, 16'hBEEF, 1'b0);
        check("single.pend", 32'(pend_valid), 32'd1);
        check("single.A_before", 32'(A), 32'h0);
        step("single1", 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0);
        check("single.A_after", 32'(A), 32'hBEEF);

        // Streaming one write per cycle.
        for (int k = 0; k < 8; k++) begin
            step("stream", 1'b0, 1'b1, 3'(k), 16'h1000 + 16'(k), 1'b0);
        end
        step("stream_drain", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream.reg%0d", k), 32'(dut_reg(k)), 32'h1000 + 32'(k));
        end

        // Stall with the stage full while a second request waits.
        step("stall_acc", 1'b0, 1'b1, 3'b010, 16'h00AA, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step("stall", 1'b0, 1'b1, 3'b011, 16'h00BB, 1'b1);
            check("stall.F", 32'(F), 32'h1002);
        end
        step("stall_rel", 1'b0, 1'b1, 3'b011, 16'h00BB, 1'b0);
        check("stall.F_after", 32'(F), 32'h00AA);
        step("stall_drain", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("stall.E_after", 32'(E), 32'h00BB);

        // Same-address ordering.
        step("same0", 1'b0, 1'b1, 3'b001, 16'h1111, 1'b0);
        step("same1", 1'b0, 1'b1, 3'b001, 16'h2222, 1'b0);
        check("same.G_mid", 32'(G), 32'h1111);
        step("same2", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("same.G_final", 32'(G), 32'h2222);

        // Reset discards a held pending write.
        step("rmid_acc", 1'b0, 1'b1, 3'b100, 16'hDEAD, 1'b1);
        step("rmid_hold", 1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        step("rmid_rst", 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        step("rmid_after", 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("rmid.D", 32'(D), 32'h0);
        check("rmid.pend", 32'(pend_valid), 32'd0);

        // Random traffic; an unaccepted request is held stable until taken.
        rv = 1'b0; ra = 3'd0; rd = '0;
        last_accepted = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!rv || last_accepted) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = 3'($urandom_range(0, 7));
                rd = 16'($urandom);
            end
            rh = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 49) == 0) begin
                step("rand_rst", 1'b1, rv, ra, rd, rh);
                rv = 1'b0;
            end else begin
                step("rand", 1'b0, rv, ra, rd, rh);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
